// File: rtl/xfer_seq_if.sv
// xfer_seq_if: command handshake, main-bus arbitration and transfer-register
// strobe bundle for xfer_seq.
//   cmd_valid/cmd_op/cmd_ready : command handshake (cmd_op 3 bits)
//   abort                      : synchronous cancel of the running command
//   bus_req/bus_gnt            : main-bus request / grant
//   busy/done/err              : status; done and err are one-cycle pulses
//   assert_* / load_*          : active-low drive and load strobes
// modport slave is the sequencer side, modport master the requester side.
interface xfer_seq_if;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic       cmd_ready;
  logic       abort;
  logic       bus_req;
  logic       bus_gnt;
  logic       busy;
  logic       done;
  logic       err;
  logic       assert_addr;
  logic       assert_xfer;
  logic       assertlow_main;
  logic       asserthigh_main;
  logic       load_xfer;
  logic       loadlow_main;
  logic       loadhigh_main;

  modport slave (
    input  cmd_valid, cmd_op, abort, bus_gnt,
    output cmd_ready, bus_req, busy, done, err,
           assert_addr, assert_xfer, assertlow_main, asserthigh_main,
           load_xfer, loadlow_main, loadhigh_main
  );

  modport master (
    output cmd_valid, cmd_op, abort, bus_gnt,
    input  cmd_ready, bus_req, busy, done, err,
           assert_addr, assert_xfer, assertlow_main, asserthigh_main,
           load_xfer, loadlow_main, loadhigh_main
  );
endinterface

// File: rtl/xfer_seq.sv
// xfer_seq: command sequencer producing active-low strobes for a transfer
// register. Main-bus commands (LOAD_MAIN16/STORE_MAIN16) request the bus,
// wait for grant, then run a low-byte phase and a high-byte phase. Transfer
// and address commands run a single phase. Each phase lasts HOLD_CYCLES
// clocks (1..15).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : xfer_seq_if.slave (handshake, arbitration, status, strobes)
module xfer_seq #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input logic       clk,
  input logic       reset,
  xfer_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_GNT = 3'd1,
    PH_A     = 3'd2,
    PH_B     = 3'd3,
    DONE     = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP          = 3'd0,
    OP_LOAD_MAIN16  = 3'd1,
    OP_STORE_MAIN16 = 3'd2,
    OP_LOAD_XFER    = 3'd3,
    OP_DRIVE_XFER   = 3'd4,
    OP_DRIVE_ADDR   = 3'd5
  } op_e;

  // Strobe bit positions inside the packed strobe vector.
  localparam int unsigned SB_ADDR   = 6;
  localparam int unsigned SB_XFER   = 5;
  localparam int unsigned SB_ALOW   = 4;
  localparam int unsigned SB_AHIGH  = 3;
  localparam int unsigned SB_LXFER  = 2;
  localparam int unsigned SB_LLOW   = 1;
  localparam int unsigned SB_LHIGH  = 0;

  localparam logic [3:0] HOLD_M1 = 4'(HOLD_CYCLES - 1);

  state_e     r_state, w_state_nxt;
  logic [2:0] r_op, w_op_nxt;
  logic [3:0] r_cnt;
  logic [6:0] r_strb_n, w_strb_n;
  logic       r_bus_req, w_bus_req;
  logic       r_done, w_done;
  logic       r_err, w_err;
  logic       w_accept;
  logic       w_main_nxt;
  logic       w_main_cur;
  logic       w_entry;

  assign w_accept   = (r_state == IDLE) && bus.cmd_valid;
  assign w_op_nxt   = w_accept ? bus.cmd_op : r_op;
  assign w_main_cur = (r_op == OP_LOAD_MAIN16) || (r_op == OP_STORE_MAIN16);
  assign w_main_nxt = (w_op_nxt == OP_LOAD_MAIN16) || (w_op_nxt == OP_STORE_MAIN16);
  assign w_entry    = ((w_state_nxt == PH_A) && (r_state != PH_A)) ||
                      ((w_state_nxt == PH_B) && (r_state != PH_B));

  // State register; outputs are registered from next-state values so each
  // strobe changes in the same cycle the state it belongs to is entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_cnt     <= '0;
      r_strb_n  <= '1;
      r_bus_req <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_op      <= w_op_nxt;
      r_strb_n  <= w_strb_n;
      r_bus_req <= w_bus_req;
      r_done    <= w_done;
      r_err     <= w_err;
      if (w_entry)
        r_cnt <= HOLD_M1;
      else if ((w_state_nxt == PH_A) || (w_state_nxt == PH_B))
        r_cnt <= r_cnt - 4'd1;
      else
        r_cnt <= '0;
    end
  end

  // Next-state logic; abort outranks grant and phase expiry.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_LOAD_MAIN16, OP_STORE_MAIN16:           w_state_nxt = WAIT_GNT;
            OP_LOAD_XFER, OP_DRIVE_XFER, OP_DRIVE_ADDR: w_state_nxt = PH_A;
            default:                                    w_state_nxt = DONE;
          endcase
        end
      end
      WAIT_GNT: begin
        if (bus.abort)        w_state_nxt = IDLE;
        else if (bus.bus_gnt) w_state_nxt = PH_A;
      end
      PH_A: begin
        if (bus.abort)          w_state_nxt = IDLE;
        else if (r_cnt == 4'd0) w_state_nxt = w_main_cur ? PH_B : DONE;
      end
      PH_B: begin
        if (bus.abort)          w_state_nxt = IDLE;
        else if (r_cnt == 4'd0) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode of the upcoming state; at most one strobe bit is cleared.
  always_comb begin
    w_strb_n  = '1;
    w_bus_req = 1'b0;
    w_done    = 1'b0;
    w_err     = 1'b0;
    case (w_state_nxt)
      WAIT_GNT: w_bus_req = w_main_nxt;
      PH_A: begin
        w_bus_req = w_main_nxt;
        case (w_op_nxt)
          OP_LOAD_MAIN16:  w_strb_n[SB_LLOW]  = 1'b0;
          OP_STORE_MAIN16: w_strb_n[SB_ALOW]  = 1'b0;
          OP_LOAD_XFER:    w_strb_n[SB_LXFER] = 1'b0;
          OP_DRIVE_XFER:   w_strb_n[SB_XFER]  = 1'b0;
          OP_DRIVE_ADDR:   w_strb_n[SB_ADDR]  = 1'b0;
          default: ;
        endcase
      end
      PH_B: begin
        w_bus_req = w_main_nxt;
        case (w_op_nxt)
          OP_LOAD_MAIN16:  w_strb_n[SB_LHIGH] = 1'b0;
          OP_STORE_MAIN16: w_strb_n[SB_AHIGH] = 1'b0;
          default: ;
        endcase
      end
      DONE: begin
        w_done = 1'b1;
        w_err  = (w_op_nxt[2:1] == 2'b11);
      end
      default: ;
    endcase
  end

  assign bus.cmd_ready       = (r_state == IDLE);
  assign bus.busy            = (r_state != IDLE);
  assign bus.bus_req         = r_bus_req;
  assign bus.done            = r_done;
  assign bus.err             = r_err;
  assign bus.assert_addr     = r_strb_n[SB_ADDR];
  assign bus.assert_xfer     = r_strb_n[SB_XFER];
  assign bus.assertlow_main  = r_strb_n[SB_ALOW];
  assign bus.asserthigh_main = r_strb_n[SB_AHIGH];
  assign bus.load_xfer       = r_strb_n[SB_LXFER];
  assign bus.loadlow_main    = r_strb_n[SB_LLOW];
  assign bus.loadhigh_main   = r_strb_n[SB_LHIGH];

endmodule

// File: tb/tb_xfer_seq.sv
// Directed bench for xfer_seq: instance a uses HOLD_CYCLES=1, instance b
// uses HOLD_CYCLES=3. Strobe vectors are packed as
// {addr, xfer, assertlow, asserthigh, load_xfer, loadlow, loadhigh}.
module tb_xfer_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;

  xfer_seq_if ifa ();
  xfer_seq_if ifb ();

  xfer_seq #(.HOLD_CYCLES(1)) u_a (.clk(clk), .reset(reset), .bus(ifa));
  xfer_seq #(.HOLD_CYCLES(3)) u_b (.clk(clk), .reset(reset), .bus(ifb));

  always #5 clk = ~clk;

  logic [6:0] sa, sb;
  assign sa = {ifa.assert_addr, ifa.assert_xfer, ifa.assertlow_main, ifa.asserthigh_main,
               ifa.load_xfer, ifa.loadlow_main, ifa.loadhigh_main};
  assign sb = {ifb.assert_addr, ifb.assert_xfer, ifb.assertlow_main, ifb.asserthigh_main,
               ifb.load_xfer, ifb.loadlow_main, ifb.loadhigh_main};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ifa.cmd_valid = 1'b0; ifa.cmd_op = 3'd0; ifa.abort = 1'b0; ifa.bus_gnt = 1'b0;
    ifb.cmd_valid = 1'b0; ifb.cmd_op = 3'd0; ifb.abort = 1'b0; ifb.bus_gnt = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if (sa !== 7'h7f) begin errors++; $display("FAIL reset_strb_a got %b exp %b", sa, 7'h7f); end
    checks++; if (sb !== 7'h7f) begin errors++; $display("FAIL reset_strb_b got %b exp %b", sb, 7'h7f); end
    checks++; if ({ifa.cmd_ready, ifa.bus_req, ifa.done, ifa.busy, ifa.err} !== 5'b10000) begin
      errors++; $display("FAIL reset_status_a got %b exp 10000", {ifa.cmd_ready, ifa.bus_req, ifa.done, ifa.busy, ifa.err}); end
    tick(); tick();
    checks++; if ({ifb.cmd_ready, ifb.bus_req, ifb.done, ifb.busy, ifb.err} !== 5'b10000) begin
      errors++; $display("FAIL reset_status_b got %b exp 10000", {ifb.cmd_ready, ifb.bus_req, ifb.done, ifb.busy, ifb.err}); end
    reset = 1'b1;
  endtask

  // Accepted on the very first edge after reset release.
  task automatic test_load_xfer();
    ifa.cmd_valid = 1'b1; ifa.cmd_op = 3'd3;
    tick();
    ifa.cmd_valid = 1'b0;
    checks++; if (sa !== 7'b1111011) begin errors++; $display("FAIL op3_phA_strb got %b exp %b", sa, 7'b1111011); end
    checks++; if ({ifa.done, ifa.busy, ifa.bus_req, ifa.cmd_ready} !== 4'b0100) begin
      errors++; $display("FAIL op3_phA_status got %b exp 0100", {ifa.done, ifa.busy, ifa.bus_req, ifa.cmd_ready}); end
    tick();
    checks++; if (sa !== 7'h7f) begin errors++; $display("FAIL op3_done_strb got %b exp %b", sa, 7'h7f); end
    checks++; if ({ifa.done, ifa.err} !== 2'b10) begin
      errors++; $display("FAIL op3_done got %b exp 10", {ifa.done, ifa.err}); end
    tick();
    checks++; if ({ifa.done, ifa.cmd_ready, ifa.busy} !== 3'b010) begin
      errors++; $display("FAIL op3_idle got %b exp 010", {ifa.done, ifa.cmd_ready, ifa.busy}); end
  endtask

  task automatic test_store_main_grant();
    ifa.cmd_valid = 1'b1; ifa.cmd_op = 3'd2; ifa.bus_gnt = 1'b0;
    tick();
    ifa.cmd_valid = 1'b0;
    ifa.cmd_op = 3'd4; // must not affect the running command
    for (int i = 0; i < 3; i++) begin
      checks++; if ({ifa.bus_req, sa} !== {1'b1, 7'h7f}) begin
        errors++; $display("FAIL op2_wait%0d got req=%b strb=%b exp req=1 strb=%b", i, ifa.bus_req, sa, 7'h7f); end
      if (i < 2) tick();
    end
    ifa.bus_gnt = 1'b1;
    tick();
    ifa.bus_gnt = 1'b0; // grant drop in a phase must be ignored
    checks++; if ({ifa.bus_req, sa} !== {1'b1, 7'b1101111}) begin
      errors++; $display("FAIL op2_phA got req=%b strb=%b exp req=1 strb=%b", ifa.bus_req, sa, 7'b1101111); end
    tick();
    checks++; if ({ifa.bus_req, sa} !== {1'b1, 7'b1110111}) begin
      errors++; $display("FAIL op2_phB got req=%b strb=%b exp req=1 strb=%b", ifa.bus_req, sa, 7'b1110111); end
    tick();
    checks++; if ({ifa.done, ifa.err, ifa.bus_req, sa} !== {3'b100, 7'h7f}) begin
      errors++; $display("FAIL op2_done got done=%b err=%b req=%b strb=%b exp 1 0 0 %b", ifa.done, ifa.err, ifa.bus_req, sa, 7'h7f); end
    tick();
    checks++; if ({ifa.done, ifa.cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL op2_idle got %b exp 01", {ifa.done, ifa.cmd_ready}); end
  endtask

  task automatic test_load_main_hold3();
    logic [6:0] exp_strb [1:8];
    logic [7:0] exp_misc [1:8]; // {done, bus_req}
    int unsigned ndone = 0;
    exp_strb = '{7'b1111101, 7'b1111101, 7'b1111101, 7'b1111110,
                 7'b1111110, 7'b1111110, 7'h7f, 7'h7f};
    exp_misc = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h10, 8'h00};
    ifb.bus_gnt = 1'b1; ifb.cmd_valid = 1'b1; ifb.cmd_op = 3'd1;
    tick();
    ifb.cmd_valid = 1'b0;
    checks++; if ({ifb.bus_req, sb} !== {1'b1, 7'h7f}) begin
      errors++; $display("FAIL op1_wait got req=%b strb=%b exp req=1 strb=%b", ifb.bus_req, sb, 7'h7f); end
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (ifb.done) ndone++;
      checks++; if (sb !== exp_strb[i]) begin
        errors++; $display("FAIL op1_strb_c%0d got %b exp %b", i, sb, exp_strb[i]); end
      checks++; if ({3'b000, ifb.done, 3'b000, ifb.bus_req} !== exp_misc[i]) begin
        errors++; $display("FAIL op1_misc_c%0d got done=%b req=%b exp %h", i, ifb.done, ifb.bus_req, exp_misc[i]); end
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL op1_done_count got %0d exp 1", ndone); end
    ifb.bus_gnt = 1'b0;
  endtask

  task automatic test_nop_and_illegal();
    logic [2:0] ops [3];
    ops = '{3'd6, 3'd7, 3'd0};
    for (int k = 0; k < 3; k++) begin
      ifa.cmd_valid = 1'b1; ifa.cmd_op = ops[k];
      tick();
      ifa.cmd_valid = 1'b0;
      checks++; if ({ifa.done, ifa.err, ifa.bus_req, sa} !== {1'b1, (ops[k] != 3'd0), 1'b0, 7'h7f}) begin
        errors++; $display("FAIL op%0d_done got done=%b err=%b req=%b strb=%b", ops[k], ifa.done, ifa.err, ifa.bus_req, sa); end
      tick();
      checks++; if ({ifa.done, ifa.err, ifa.cmd_ready} !== 3'b001) begin
        errors++; $display("FAIL op%0d_after got %b exp 001", ops[k], {ifa.done, ifa.err, ifa.cmd_ready}); end
    end
  endtask

  task automatic test_abort_wait();
    ifa.cmd_valid = 1'b1; ifa.cmd_op = 3'd1; ifa.bus_gnt = 1'b0;
    tick();
    ifa.cmd_valid = 1'b0;
    checks++; if ({ifa.bus_req, ifa.busy} !== 2'b11) begin
      errors++; $display("FAIL abort_pre got %b exp 11", {ifa.bus_req, ifa.busy}); end
    ifa.abort = 1'b1;
    tick();
    ifa.abort = 1'b0;
    checks++; if ({ifa.cmd_ready, ifa.busy, ifa.bus_req, ifa.done, sa} !== {4'b1000, 7'h7f}) begin
      errors++; $display("FAIL abort_idle got rdy=%b busy=%b req=%b done=%b strb=%b exp 1 0 0 0 %b",
                         ifa.cmd_ready, ifa.busy, ifa.bus_req, ifa.done, sa, 7'h7f); end
    tick();
    checks++; if (ifa.done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b exp 0", ifa.done); end
  endtask

  task automatic test_async_reset();
    ifa.cmd_valid = 1'b1; ifa.cmd_op = 3'd4;
    tick();
    ifa.cmd_valid = 1'b0;
    checks++; if (sa !== 7'b1011111) begin errors++; $display("FAIL op4_phA got %b exp %b", sa, 7'b1011111); end
    #2 reset = 1'b0;
    #1;
    checks++; if ({ifa.busy, ifa.cmd_ready, sa} !== {2'b01, 7'h7f}) begin
      errors++; $display("FAIL async_rst got busy=%b rdy=%b strb=%b exp 0 1 %b", ifa.busy, ifa.cmd_ready, sa, 7'h7f); end
    tick();
    reset = 1'b1;
    ifa.cmd_valid = 1'b1; ifa.cmd_op = 3'd5;
    tick();
    ifa.cmd_valid = 1'b0;
    checks++; if (sa !== 7'b0111111) begin errors++; $display("FAIL op5_after_rst got %b exp %b", sa, 7'b0111111); end
    tick();
    checks++; if ({ifa.done, sa} !== {1'b1, 7'h7f}) begin
      errors++; $display("FAIL op5_done got done=%b strb=%b exp 1 %b", ifa.done, sa, 7'h7f); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_xfer();
    test_store_main_grant();
    test_load_main_hold3();
    test_nop_and_illegal();
    test_abort_wait();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/xfer_seq.md
XFER_SEQ -- requirements
Module: xfer_seq

Interface
REQ-001 The block SHALL have one parameter, HOLD_CYCLES, with default 1 and legal range 1..15; it sets the number of clocks each strobe phase lasts.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  in  1  single clock; all state changes occur on its rising edge.
REQ-004 reset  in  1  asynchronous active-low reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_op  in  3  opcode: 0 NOP, 1 LOAD_MAIN16, 2 STORE_MAIN16, 3 LOAD_XFER, 4 DRIVE_XFER, 5 DRIVE_ADDR; 6 and 7 are illegal.
REQ-007 cmd_ready  out  1  high when a command can be accepted.
REQ-008 abort  in  1  synchronous cancel of the current command.
REQ-009 bus_req  out  1  main-bus ownership request.
REQ-010 bus_gnt  in  1  main-bus grant from the arbiter.
REQ-011 busy  out  1  high in any state other than IDLE.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 err  out  1  one-cycle illegal-opcode pulse.
REQ-014 assert_addr, assert_xfer, assertlow_main, asserthigh_main  out  1 each  active-low drive strobes to the transfer register.
REQ-015 load_xfer, loadlow_main, loadhigh_main  out  1 each  active-low load strobes to the transfer register.

Function
REQ-016 The states SHALL be IDLE, WAIT_GNT, PH_A, PH_B and DONE.
REQ-017 cmd_ready SHALL equal (state==IDLE).
REQ-018 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both high.
REQ-019 On acceptance, opcodes 1 and 2 SHALL go to WAIT_GNT; opcodes 3, 4 and 5 SHALL go to PH_A; opcodes 0, 6 and 7 SHALL go to DONE.
REQ-020 bus_req SHALL be high in WAIT_GNT, PH_A and PH_B for opcodes 1 and 2, and low everywhere else, including DONE.
REQ-021 In WAIT_GNT, a sampled bus_gnt=1 SHALL cause the transition to PH_A; the block SHALL wait in WAIT_GNT indefinitely otherwise.
REQ-022 bus_gnt SHALL be ignored outside WAIT_GNT; a grant drop during PH_A or PH_B does not stall the command.
REQ-023 The PH_A strobe SHALL be: op1 loadlow_main, op2 assertlow_main, op3 load_xfer, op4 assert_xfer, op5 assert_addr.
REQ-024 The PH_B strobe SHALL be: op1 loadhigh_main, op2 asserthigh_main; ops 3 to 5 have no PH_B and go PH_A to DONE.
REQ-025 Each phase SHALL last exactly HOLD_CYCLES clocks, counted by a 4-bit down-counter loaded on phase entry.
REQ-026 All strobes SHALL be registered outputs with no glitches, and at most one strobe SHALL be low in any cycle.
REQ-027 The PH_A to PH_B transition SHALL have zero idle cycles between strobes.
REQ-028 done SHALL be high for exactly the one cycle spent in DONE; DONE then returns to IDLE.
REQ-029 err SHALL be high together with done for opcodes 6 and 7.
REQ-030 abort=1 sampled in WAIT_GNT, PH_A or PH_B SHALL go directly to IDLE with no done pulse; all strobes and bus_req are high/low respectively in the following cycle.
REQ-031 abort SHALL be ignored in IDLE and DONE.
REQ-032 The opcode SHALL be latched at acceptance; cmd_op changes after acceptance have no effect.

Reset
REQ-033 reset low SHALL immediately, without a clock edge, force: state IDLE, all seven strobes 1, bus_req 0, done 0, err 0, busy 0, counter 0.
REQ-034 cmd_ready SHALL be 1 while reset is low.
REQ-035 On reset release, the first acceptance SHALL be possible at the next rising edge.

Verification
REQ-036 Reset: hold reset low -> all strobes 1, cmd_ready 1, bus_req 0, done 0, busy 0.
REQ-037 HOLD=1, op3 accepted at edge N -> load_xfer low during N..N+1 only, done high during N+1..N+2, cmd_ready 1 after edge N+2.
REQ-038 HOLD=1, op2 with bus_gnt raised 3 cycles after acceptance -> bus_req high from N, no strobe before grant; then assertlow_main low 1 cycle, asserthigh_main low the next cycle, then done with bus_req 0.
REQ-039 HOLD=3, op1 with bus_gnt tied 1 -> loadlow_main low 3 cycles, then loadhigh_main low 3 cycles; never both low; exactly 1 done.
REQ-040 Op6 accepted -> err and done high for the same single cycle; no strobe toggles; bus_req stays 0.
REQ-041 abort during WAIT_GNT, and separately async reset during PH_A of op4 -> abort: IDLE next cycle with no done; reset: assert_xfer returns to 1 immediately without a clock, busy 0.
